detect_event_logger: RTL and testbench

//  Downstream consumer of the "10000001" sequence detector's one-cycle Y output.
//  - Timestamps each detection against a free-running cycle counter.
//  - Buffers the timestamps in a small first-word-fall-through FIFO, drained by a valid/ready handshake.
//  - Keeps a saturating detection count and a sticky overflow flag for status readout.

---
 rtl/detect_event_logger.sv | 199 +++++++++++++++++++
 tb/tb_detect_event_logger.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/detect_event_logger.sv
// -----------------------------------------------------------------------------
// detect_event_logger
//
// Purpose:
//   Sits behind the "10000001" sequence detector. It turns the detector's Y
//   output into rising-edge events. Each event is stamped with the value of a
//   free-running cycle counter. The stamps are queued in a small
//   first-word-fall-through FIFO, and a consumer drains the FIFO through a
//   valid/ready handshake. The block also keeps a saturating event count and
//   a sticky overflow flag for status readout.
//
// Ports:
//   clk       in   1              rising-edge clock
//   rst       in   1              synchronous reset, active low
//   det       in   1              detector output, synchronous to clk
//   clr       in   1              synchronous clear of FIFO, ev_count, ovf
//                                 (the timestamp counter keeps running)
//   ev_valid  out  1              FIFO head is valid
//   ev_ready  in   1              consumer takes the head when ev_valid & ev_ready
//   ev_ts     out  TS_W           timestamp at FIFO head, 0 when empty
//   ev_count  out  CNT_W          events seen since reset/clr, saturating
//   ovf       out  1              sticky: an event was dropped on a full FIFO
//   level     out  log2(DEPTH)+1  FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module detect_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     det,
  input  logic                     clr,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [TS_W-1:0]          ev_ts,
  output logic [CNT_W-1:0]         ev_count,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] COUNT_MAX  = {CNT_W{1'b1}};

  // Occupancy classes, decoded from the level register. No separate state
  // register is kept, so the class can never disagree with the level.
  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [TS_W-1:0]  ts_reg,     ts_next;
  logic             det_q_reg;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [LVL_W-1:0] level_reg,  level_next;
  logic [CNT_W-1:0] count_reg,  count_next;
  logic             ovf_reg,    ovf_next;

  logic [TS_W-1:0]  entries [DEPTH];

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic [1:0] fifo_state;
  logic       is_full;
  logic       event_pulse;
  logic       push;
  logic       pop;
  logic       wr_en;
  logic       drop;

  always_comb begin
    fifo_state = ST_PARTIAL;
    if (level_reg == '0) begin
      fifo_state = ST_EMPTY;
    end else if (level_reg == LEVEL_FULL) begin
      fifo_state = ST_FULL;
    end
  end

  assign is_full     = (fifo_state == ST_FULL);
  assign ev_valid    = (fifo_state != ST_EMPTY);

  // Only the rising edge of det counts as an event. A long high pulse is
  // therefore logged once.
  assign event_pulse = det & ~det_q_reg;

  // clr suppresses both the push and the pop in its cycle. The whole FIFO is
  // discarded anyway, and the event must not be counted.
  assign push  = event_pulse & ~clr;
  assign pop   = ev_valid & ev_ready & ~clr;

  // When the FIFO is full, a same-cycle pop frees the slot under wr_ptr, which
  // equals rd_ptr in that case. The new entry therefore lands behind the
  // remaining DEPTH-1 entries.
  assign wr_en = push & (~is_full | pop);
  assign drop  = push & is_full & ~pop;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    ts_next     = ts_reg + 1'b1;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    level_next  = level_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg;

    if (clr) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      level_next  = '0;
      count_next  = '0;
      ovf_next    = 1'b0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      if (wr_en) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end

      unique case ({wr_en, pop})
        2'b10:   level_next = level_reg + 1'b1;
        2'b01:   level_next = level_reg - 1'b1;
        default: level_next = level_reg;
      endcase

      // A dropped event still counts as a detection.
      if (push && (count_reg != COUNT_MAX)) begin
        count_next = count_reg + 1'b1;
      end

      if (drop) begin
        ovf_next = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      ts_reg     <= '0;
      det_q_reg  <= 1'b0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      ts_reg     <= ts_next;
      det_q_reg  <= det;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      level_reg  <= level_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage: one register per slot, written with the current timestamp.
  // The contents need no reset because ev_ts is masked whenever the FIFO is
  // empty.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [TS_W-1:0] slot_reg;

      always_ff @(posedge clk) begin
        if (rst && wr_en && (wr_ptr_reg == PTR_W'(gi))) begin
          slot_reg <= ts_reg;
        end
      end

      assign entries[gi] = slot_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs: these are registers or decodes of registers only. No path runs
  // from det to any output.
  // ---------------------------------------------------------------------------
  assign ev_ts    = ev_valid ? entries[rd_ptr_reg] : '0;
  assign ev_count = count_reg;
  assign ovf      = ovf_reg;
  assign level    = level_reg;

endmodule

// File: tb/tb_detect_event_logger.sv
// -----------------------------------------------------------------------------
// tb_detect_event_logger
//
// Drives detect_event_logger with directed scenarios and then with random
// traffic. A queue-based model runs in parallel and predicts every output
// after each clock edge. The bench uses small parameters so that timestamp
// wrap and count saturation occur quickly.
// -----------------------------------------------------------------------------
module tb_detect_event_logger;

  localparam int TS_W      = 8;
  localparam int DEPTH     = 4;
  localparam int CNT_W     = 3;
  localparam int LVL_W     = $clog2(DEPTH) + 1;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int TS_MOD    = (1 << TS_W);

  logic             clk = 1'b0;
  logic             rst;
  logic             det;
  logic             clr;
  logic             ev_valid;
  logic             ev_ready;
  logic [TS_W-1:0]  ev_ts;
  logic [CNT_W-1:0] ev_count;
  logic             ovf;
  logic [LVL_W-1:0] level;

  always #5 clk = ~clk;

  detect_event_logger #(
    .TS_W  (TS_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .det      (det),
    .clr      (clr),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_ts    (ev_ts),
    .ev_count (ev_count),
    .ovf      (ovf),
    .level    (level)
  );

  // Reference model state. m_ts holds the timestamp of the cycle in progress.
  int m_q[$];
  int m_ts;
  int m_cnt;
  bit m_ovf;
  bit m_prev;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge, given the inputs of the cycle that
  // is ending.
  task automatic model_edge(input bit d, input bit r, input bit c, input bit s);
    bit ev;
    bit pop;
    if (!s) begin
      m_q.delete();
      m_ts   = 0;
      m_prev = 0;
      m_cnt  = 0;
      m_ovf  = 0;
    end else begin
      ev  = d && !m_prev;
      pop = (m_q.size() > 0) && r;
      if (c) begin
        m_q.delete();
        m_cnt = 0;
        m_ovf = 0;
      end else begin
        if (pop) begin
          $display("pop   ts=%0d level_before=%0d", m_q[0], m_q.size());
          void'(m_q.pop_front());
        end
        if (ev) begin
          if (m_q.size() < DEPTH) m_q.push_back(m_ts);
          else m_ovf = 1;
          if (m_cnt < CNT_MAX) m_cnt++;
        end
      end
      m_prev = d;
      m_ts   = (m_ts + 1) % TS_MOD;
    end
  endtask

  // Drive one cycle, clock it, and compare all outputs against the model.
  task automatic step(input bit d, input bit r, input bit c, input bit s);
    det      = d;
    ev_ready = r;
    clr      = c;
    rst      = s;
    @(posedge clk);
    model_edge(d, r, c, s);
    #1;
    check("ev_valid", ev_valid, (m_q.size() != 0));
    check("ev_ts",    ev_ts,    (m_q.size() != 0) ? m_q[0] : 0);
    check("ev_count", ev_count, m_cnt);
    check("ovf",      ovf,      m_ovf);
    check("level",    level,    m_q.size());
  endtask

  task automatic idle_until(input int t);
    for (int i = 0; i < 2 * TS_MOD && m_ts != t; i++) step(0, 0, 0, 1);
    check("reach_ts", m_ts, t);
  endtask

  // Pop the expected entries in order, then confirm that the FIFO is empty.
  task automatic drain_expect(input string tag, input int exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      check(tag, ev_ts, exp[i]);
      step(0, 1, 0, 1);
    end
    check({tag, "_empty"}, ev_valid, 0);
  endtask

  initial begin
    int t;
    det = 0; ev_ready = 0; clr = 0; rst = 0;

    // T1: reset held with det high.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    check("t1_valid", ev_valid, 0);
    check("t1_count", ev_count, 0);
    check("t1_level", level, 0);
    check("t1_ovf",   ovf, 0);

    // T2: a single event at ts=5, then popped.
    idle_until(5);
    step(1, 0, 0, 1);
    check("t2_valid", ev_valid, 1);
    check("t2_ts",    ev_ts, 5);
    check("t2_count", ev_count, 1);
    check("t2_level", level, 1);
    step(0, 1, 0, 1);
    check("t2_popped", ev_valid, 0);

    // T3: det held for 10 cycles yields a single entry.
    step(0, 0, 1, 1);
    idle_until(20);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    check("t3_level", level, 1);
    check("t3_ts",    ev_ts, 20);
    check("t3_count", ev_count, 1);
    drain_expect("t3_drain", '{20});

    // T4: overflow. Five pulses after the timestamp wraps.
    step(0, 0, 1, 1);
    idle_until(10);
    for (int k = 0; k < 10; k++) step((k % 2) == 0, 0, 0, 1);
    check("t4_level", level, 4);
    check("t4_ovf",   ovf, 1);
    check("t4_count", ev_count, 5);

    // T5: push and pop on a full FIFO.
    t = m_ts;
    step(1, 1, 0, 1);
    check("t5_level", level, 4);
    check("t5_ovf",   ovf, 1);
    step(0, 0, 0, 1);
    drain_expect("t5_drain", '{12, 14, 16, t});

    // T6: count saturation, then clr together with a pulse.
    step(0, 0, 1, 1);
    for (int k = 0; k < 18; k++) step((k % 2) == 0, 0, 0, 1);
    check("t6_sat", ev_count, 7);
    step(1, 0, 1, 1);
    check("t6_count", ev_count, 0);
    check("t6_level", level, 0);
    check("t6_ovf",   ovf, 0);
    step(0, 0, 0, 1);
    t = m_ts;
    step(1, 0, 0, 1);
    check("t6_ts_running", ev_ts, t);

    // Reset asserted mid-stream discards buffered entries.
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);
    check("rst_mid_level", level, 0);
    check("rst_mid_valid", ev_valid, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 4),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 199) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
